// File: rtl/dmem_lsu.sv
// Load/store unit between the CPU memory stage and a word-wide data memory.
// One access in flight at a time; sub-word stores use read-modify-write
// because the memory port has no byte enables.
//
// state  | meaning
// IDLE   | ready for a CPU request
// LOAD   | memory read; lane extracted and extended into rdata
// RMW_RD | read old word and merge the store byte/half into it
// WRITE  | memory write strobe with the merged word
// DONE   | done pulse, err reports rejection
module dmem_lsu #(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ready,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic        mem_write,
  output logic [31:0] mem_adr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd
);

  typedef enum logic [2:0] {IDLE, LOAD, RMW_RD, WRITE, DONE} state_t;

  localparam logic [29:0] WORD_LIMIT = 30'(MEM_WORDS);

  state_t      state, state_nx;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] merge_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        acc_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_ext;
  logic [31:0] merged;

  // Request decode: reject reserved size, misalignment and out-of-range words
  always_comb begin
    accept  = (state == IDLE) && req;
    acc_err = (size == 2'b11)
           || ((size == 2'b01) && addr[0])
           || ((size == 2'b10) && (addr[1:0] != 2'b00))
           || (addr[31:2] >= WORD_LIMIT);
  end

  // Lane extraction with sign/zero extension for loads
  always_comb begin
    lane_b = 8'h00;
    case (addr_q[1:0])
      2'd0: lane_b = mem_rd[7:0];
      2'd1: lane_b = mem_rd[15:8];
      2'd2: lane_b = mem_rd[23:16];
      default: lane_b = mem_rd[31:24];
    endcase
    lane_h = addr_q[1] ? mem_rd[31:16] : mem_rd[15:0];
    case (size_q)
      2'b00:   load_ext = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_ext = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_ext = mem_rd;
    endcase
  end

  // Merge of store byte/half into the word read back from memory
  always_comb begin
    merged = mem_rd;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0: merged[7:0]   = wdata_q[7:0];
        2'd1: merged[15:8]  = wdata_q[7:0];
        2'd2: merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[31:16] = wdata_q[15:0];
    end else begin
      merged[15:0] = wdata_q[15:0];
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (acc_err)              state_nx = DONE;
          else if (!we)             state_nx = LOAD;
          else if (size == 2'b10)   state_nx = WRITE;
          else                      state_nx = RMW_RD;
        end
      end
      LOAD:    state_nx = DONE;
      RMW_RD:  state_nx = WRITE;
      WRITE:   state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register, request latches, merge and load result registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      merge_q <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept) begin
        size_q  <= size;
        uns_q   <= uns;
        addr_q  <= addr;
        wdata_q <= wdata;
        err_q   <= acc_err;
        if (we && (size == 2'b10)) merge_q <= wdata;
      end
      if (state == LOAD)   rdata_q <= load_ext;
      if (state == RMW_RD) merge_q <= merged;
    end
  end

  // Outputs decoded from state; the write strobe is killed by reset
  always_comb begin
    ready     = (state == IDLE);
    done      = (state == DONE);
    err       = (state == DONE) && err_q;
    mem_write = (state == WRITE) && !reset;
    mem_adr   = {addr_q[31:2], 2'b00};
    mem_wd    = merge_q;
    rdata     = rdata_q;
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu with a behavioural word memory.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset, req, we, uns;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, done, err, mem_write;
  logic [31:0] rdata, mem_adr, mem_wd, mem_rd;

  logic [31:0] tb_mem [0:255];
  logic        poke_en = 1'b0;
  logic [7:0]  poke_idx = 8'h0;
  logic [31:0] poke_val = 32'h0;

  int errors = 0;
  int checks = 0;

  int          dc, wc, wn;
  logic        es, rs;
  logic [31:0] wd, ad;

  always #5 clk = ~clk;

  dmem_lsu #(.MEM_WORDS(256)) dut (
    .clk(clk), .reset(reset), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .ready(ready), .done(done), .err(err),
    .rdata(rdata), .mem_write(mem_write), .mem_adr(mem_adr), .mem_wd(mem_wd),
    .mem_rd(mem_rd)
  );

  assign mem_rd = tb_mem[mem_adr[9:2]];

  always @(posedge clk) begin
    if (mem_write) tb_mem[mem_adr[9:2]] <= mem_wd;
    else if (poke_en) tb_mem[poke_idx] <= poke_val;
  end

  task automatic poke(input logic [7:0] idx, input logic [31:0] val);
    @(negedge clk);
    poke_idx = idx; poke_val = val; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  // Issue one access and record what happened, relative to acceptance cycle T
  task automatic run_op(input logic op_we, input logic [1:0] op_size, input logic op_uns,
                        input logic [31:0] op_addr, input logic [31:0] op_wdata);
    dc = -1; wc = -1; wn = 0; es = 1'b0; wd = 32'h0; ad = 32'h0;
    @(negedge clk);
    rs = ready;
    req = 1'b1; we = op_we; size = op_size; uns = op_uns; addr = op_addr; wdata = op_wdata;
    @(negedge clk);
    req = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (mem_write) begin wn++; wc = k; wd = mem_wd; ad = mem_adr; end
      if (done) begin dc = k; es = err; break; end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
    addr = 32'h0; wdata = 32'h0;
    repeat (2) @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0 || err !== 1'b0 || mem_write !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b done=%b err=%b mem_write=%b want 1 0 0 0",
               ready, done, err, mem_write);
    end
    checks++;
    if (rdata !== 32'h0 || mem_adr !== 32'h0 || mem_wd !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h mem_adr=%h mem_wd=%h want all 0", rdata, mem_adr, mem_wd);
    end
    req = 1'b1; we = 1'b0; size = 2'b10; addr = 32'h0;
    @(negedge clk);
    reset = 1'b0; req = 1'b0;
    @(negedge clk);
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL req_during_reset: ready=%b done=%b want 1 0", ready, done);
    end
  endtask

  task automatic test_word;
    run_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    checks++;
    if (rs !== 1'b1 || dc !== 2 || wn !== 1 || wc !== 1 || es !== 1'b0) begin
      errors++;
      $display("FAIL sw_timing: ready=%b done_cyc=%0d writes=%0d wr_cyc=%0d err=%b want 1 2 1 1 0",
               rs, dc, wn, wc, es);
    end
    checks++;
    if (wd !== 32'hDEADBEEF || ad !== 32'h10) begin
      errors++;
      $display("FAIL sw_data: mem_wd=%h mem_adr=%h want deadbeef 00000010", wd, ad);
    end
    run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    checks++;
    if (dc !== 2 || wn !== 0 || es !== 1'b0 || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL lw: done_cyc=%0d writes=%0d err=%b rdata=%h want 2 0 0 deadbeef",
               dc, wn, es, rdata);
    end
  endtask

  task automatic test_byte;
    poke(8'd4, 32'h11223344);
    run_op(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AB);
    checks++;
    if (dc !== 3 || wn !== 1 || wc !== 2 || es !== 1'b0) begin
      errors++;
      $display("FAIL sb_timing: done_cyc=%0d writes=%0d wr_cyc=%0d err=%b want 3 1 2 0", dc, wn, wc, es);
    end
    checks++;
    if (wd !== 32'h11AB3344 || tb_mem[4] !== 32'h11AB3344) begin
      errors++;
      $display("FAIL sb_merge: mem_wd=%h mem=%h want 11ab3344", wd, tb_mem[4]);
    end
    run_op(1'b0, 2'b00, 1'b0, 32'h12, 32'h0);
    checks++;
    if (rdata !== 32'hFFFFFFAB || dc !== 2) begin
      errors++;
      $display("FAIL lb: rdata=%h done_cyc=%0d want ffffffab 2", rdata, dc);
    end
    run_op(1'b0, 2'b00, 1'b1, 32'h12, 32'h0);
    checks++;
    if (rdata !== 32'h000000AB) begin
      errors++;
      $display("FAIL lbu: rdata=%h want 000000ab", rdata);
    end
    run_op(1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
    checks++;
    if (rdata !== 32'h00000011) begin
      errors++;
      $display("FAIL lbu_lane3: rdata=%h want 00000011", rdata);
    end
  endtask

  task automatic test_half;
    poke(8'd0, 32'h80017FFF);
    run_op(1'b0, 2'b01, 1'b0, 32'h0, 32'h0);
    checks++;
    if (rdata !== 32'h00007FFF) begin
      errors++;
      $display("FAIL lh_0: rdata=%h want 00007fff", rdata);
    end
    run_op(1'b0, 2'b01, 1'b0, 32'h2, 32'h0);
    checks++;
    if (rdata !== 32'hFFFF8001) begin
      errors++;
      $display("FAIL lh_2: rdata=%h want ffff8001", rdata);
    end
    run_op(1'b0, 2'b01, 1'b1, 32'h2, 32'h0);
    checks++;
    if (rdata !== 32'h00008001) begin
      errors++;
      $display("FAIL lhu_2: rdata=%h want 00008001", rdata);
    end
    run_op(1'b1, 2'b01, 1'b0, 32'h2, 32'hFFFF1234);
    checks++;
    if (wd !== 32'h12347FFF || dc !== 3 || wc !== 2 || tb_mem[0] !== 32'h12347FFF) begin
      errors++;
      $display("FAIL sh_2: mem_wd=%h done_cyc=%0d wr_cyc=%0d mem=%h want 12347fff 3 2 12347fff",
               wd, dc, wc, tb_mem[0]);
    end
  endtask

  task automatic test_boundary;
    poke(8'd255, 32'hCAFEF00D);
    run_op(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
    checks++;
    if (dc !== 2 || es !== 1'b0 || rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL lw_last_word: done_cyc=%0d err=%b rdata=%h want 2 0 cafef00d", dc, es, rdata);
    end
  endtask

  task automatic test_errors;
    logic        e_we   [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [1:0]  e_size [4] = '{2'b10, 2'b01, 2'b11, 2'b10};
    logic [31:0] e_addr [4] = '{32'h3, 32'h1, 32'h0, 32'h400};
    for (int i = 0; i < 4; i++) begin
      run_op(e_we[i], e_size[i], 1'b0, e_addr[i], 32'h5A5A5A5A);
      checks++;
      if (dc !== 1 || es !== 1'b1 || wn !== 0 || rdata !== 32'hCAFEF00D) begin
        errors++;
        $display("FAIL err_case%0d: done_cyc=%0d err=%b writes=%0d rdata=%h want 1 1 0 cafef00d",
                 i, dc, es, wn, rdata);
      end
    end
    checks++;
    if (mem_adr !== 32'h400 || tb_mem[0] !== 32'h12347FFF) begin
      errors++;
      $display("FAIL err_side: mem_adr=%h mem0=%h want 00000400 12347fff", mem_adr, tb_mem[0]);
    end
  endtask

  task automatic test_back_to_back;
    int bad = 0;
    int ndone = 0;
    @(negedge clk);
    req = 1'b1; we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h0;
    for (int k = 0; k < 12; k++) begin
      if (ready !== (k % 3 == 0)) bad++;
      if (done !== (k % 3 == 2)) bad++;
      if (done === 1'b1) begin
        ndone++;
        if (err !== 1'b0 || rdata !== 32'h12347FFF) bad++;
      end
      @(negedge clk);
    end
    req = 1'b0;
    checks++;
    if (bad !== 0 || ndone !== 4) begin
      errors++;
      $display("FAIL back_to_back: pattern_errors=%0d done_pulses=%0d want 0 4", bad, ndone);
    end
  endtask

  task automatic test_reset_midop;
    int late_done = 0;
    poke(8'd8, 32'h55667788);
    @(negedge clk);
    req = 1'b1; we = 1'b1; size = 2'b00; addr = 32'h21; wdata = 32'h99;
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (mem_write !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_write: mem_write=%b done=%b want 0 0", mem_write, done);
    end
    @(negedge clk);
    reset = 1'b0;
    checks++;
    if (ready !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL after_reset: ready=%b done=%b want 1 0", ready, done);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done !== 1'b0) late_done++;
    end
    checks++;
    if (late_done !== 0 || tb_mem[8] !== 32'h55667788) begin
      errors++;
      $display("FAIL abandoned_op: late_done=%0d mem=%h want 0 55667788", late_done, tb_mem[8]);
    end
    run_op(1'b1, 2'b00, 1'b0, 32'h21, 32'h99);
    checks++;
    if (dc !== 3 || tb_mem[8] !== 32'h55669988) begin
      errors++;
      $display("FAIL sb_after_reset: done_cyc=%0d mem=%h want 3 55669988", dc, tb_mem[8]);
    end
  endtask

  initial begin
    test_reset;
    test_word;
    test_byte;
    test_half;
    test_boundary;
    test_errors;
    test_back_to_back;
    test_reset_midop;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
